// File: rtl/kl_sram_if.sv
`default_nettype none
// ============================================================================
// Module      : kl_sram_if
// Description : KLink request/response bundle between a KLink master and the
//               kl_sram slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface kl_sram_if;
    logic [31:0] kl_req_addr;
    logic        kl_req_wen;
    logic [63:0] kl_req_wdata;
    logic [7:0]  kl_req_wmask;
    logic [2:0]  kl_req_size;
    logic [4:0]  kl_req_srcid;
    logic        kl_req_valid;
    logic        kl_req_ready;
    logic [63:0] kl_resp_rdata;
    logic        kl_resp_ren;
    logic [2:0]  kl_resp_size;
    logic [4:0]  kl_resp_dstid;
    logic        kl_resp_valid;
    logic        kl_resp_ready;

    modport master (
        output kl_req_addr, kl_req_wen, kl_req_wdata, kl_req_wmask,
               kl_req_size, kl_req_srcid, kl_req_valid, kl_resp_ready,
        input  kl_req_ready, kl_resp_rdata, kl_resp_ren, kl_resp_size,
               kl_resp_dstid, kl_resp_valid
    );

    modport slave (
        input  kl_req_addr, kl_req_wen, kl_req_wdata, kl_req_wmask,
               kl_req_size, kl_req_srcid, kl_req_valid, kl_resp_ready,
        output kl_req_ready, kl_resp_rdata, kl_resp_ren, kl_resp_size,
               kl_resp_dstid, kl_resp_valid
    );
endinterface
`default_nettype wire

// File: rtl/kl_sram.sv
`default_nettype none
// ============================================================================
// Module      : kl_sram
// Description : KLink slave backed by a 64-bit synchronous SRAM; single-beat
//               and burst reads/writes with byte masks, one transaction at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module kl_sram #(
    parameter int DEPTH_LOG2 = 12
) (
    input  wire logic  clk,
    input  wire logic  rst,
    kl_sram_if.slave   kl
);

    localparam int c_DEPTH = 2 ** DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WDATA = 2'd1,
        S_WACK  = 2'd2,
        S_RDATA = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [DEPTH_LOG2-1:0]   r_idx;
    logic [2:0]              r_cnt;
    logic [2:0]              r_size;
    logic [4:0]              r_dstid;
    logic [63:0]             r_rdata;
    logic [63:0]             r_mem [c_DEPTH];

    logic                    w_req_ready;
    logic                    w_resp_valid;
    logic                    w_resp_ren;
    logic                    w_req_hs;
    logic                    w_resp_hs;
    logic [DEPTH_LOG2-1:0]   w_addr_idx;
    logic [2:0]              w_esize;
    logic [2:0]              w_beats_m1;
    logic                    w_mem_we;
    logic                    w_mem_re;
    logic [DEPTH_LOG2-1:0]   w_mem_widx;
    logic [DEPTH_LOG2-1:0]   w_mem_ridx;
    logic                    w_unused;

    assign w_req_hs   = kl.kl_req_valid & w_req_ready;
    assign w_resp_hs  = w_resp_valid & kl.kl_resp_ready;
    assign w_addr_idx = kl.kl_req_addr[DEPTH_LOG2+2:3];
    assign w_unused   = ^{kl.kl_req_addr[2:0], kl.kl_req_addr[31:DEPTH_LOG2+3]};

    always_comb begin
        w_esize = kl.kl_req_size;
        if (kl.kl_req_size < 3'd3) begin
            w_esize = 3'd3;
        end else if (kl.kl_req_size == 3'd7) begin
            w_esize = 3'd6;
        end
    end

    always_comb begin
        case (w_esize)
            3'd3:    w_beats_m1 = 3'd0;
            3'd4:    w_beats_m1 = 3'd1;
            3'd5:    w_beats_m1 = 3'd3;
            default: w_beats_m1 = 3'd7;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // r_cnt is the number of beats still to come after the current one.
    always_comb begin
        w_next       = r_state;
        w_req_ready  = 1'b0;
        w_resp_valid = 1'b0;
        w_resp_ren   = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_widx   = r_idx;
        w_mem_re     = 1'b0;
        w_mem_ridx   = r_idx;
        case (r_state)
            S_IDLE: begin
                w_req_ready = ~rst;
                if (w_req_hs) begin
                    if (kl.kl_req_wen) begin
                        w_mem_we   = 1'b1;
                        w_mem_widx = w_addr_idx;
                        w_next     = (w_beats_m1 == 3'd0) ? S_WACK : S_WDATA;
                    end else begin
                        w_mem_re   = 1'b1;
                        w_mem_ridx = w_addr_idx;
                        w_next     = S_RDATA;
                    end
                end
            end
            S_WDATA: begin
                w_req_ready = ~rst;
                if (w_req_hs) begin
                    w_mem_we = 1'b1;
                    if (r_cnt == 3'd0) begin
                        w_next = S_WACK;
                    end
                end
            end
            S_WACK: begin
                w_resp_valid = 1'b1;
                if (w_resp_hs) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_resp_valid = 1'b1;
                w_resp_ren   = 1'b1;
                if (w_resp_hs) begin
                    if (r_cnt == 3'd0) begin
                        w_next = S_IDLE;
                    end else begin
                        w_mem_re = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_cnt   <= 3'd0;
            r_size  <= 3'd0;
            r_dstid <= 5'd0;
            r_rdata <= 64'd0;
        end else begin
            if (r_state == S_IDLE && w_req_hs) begin
                r_size  <= w_esize;
                r_dstid <= kl.kl_req_srcid;
                r_idx   <= w_addr_idx + DEPTH_LOG2'(1);
                r_cnt   <= kl.kl_req_wen ? (w_beats_m1 - 3'd1) : w_beats_m1;
            end else if ((r_state == S_WDATA && w_req_hs) || w_mem_re) begin
                r_idx   <= r_idx + DEPTH_LOG2'(1);
                r_cnt   <= r_cnt - 3'd1;
            end
            // Output register only moves on a read, so it holds under back-pressure.
            if (w_mem_re) begin
                r_rdata <= r_mem[w_mem_ridx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (kl.kl_req_wmask[b]) begin
                    r_mem[w_mem_widx][8*b +: 8] <= kl.kl_req_wdata[8*b +: 8];
                end
            end
        end
    end

    assign kl.kl_req_ready  = w_req_ready;
    assign kl.kl_resp_valid = w_resp_valid;
    assign kl.kl_resp_ren   = w_resp_ren;
    assign kl.kl_resp_rdata = (r_state == S_RDATA) ? r_rdata : 64'd0;
    assign kl.kl_resp_size  = r_size;
    assign kl.kl_resp_dstid = r_dstid;

endmodule
`default_nettype wire

// File: tb/tb_kl_sram.sv
`default_nettype none
// ============================================================================
// Module      : tb_kl_sram
// Description : Self-checking scoreboard bench for kl_sram (16-word array).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kl_sram;

    localparam int c_DL    = 4;
    localparam int c_WORDS = 16;

    typedef struct {
        logic [63:0] rdata;
        logic        ren;
        logic [2:0]  size;
        logic [4:0]  dstid;
        int          ecyc;
    } exp_t;

    logic        clk;
    logic        rst;
    int          cyc;
    int          n_checks;
    int          n_errors;
    int          last_hs;
    logic        bp_mode;
    logic [3:0]  bp_pat;
    logic [63:0] m_mem [c_WORDS];
    exp_t        q[$];

    kl_sram_if u_if();

    kl_sram #(.DEPTH_LOG2(c_DL)) u_dut (
        .clk (clk),
        .rst (rst),
        .kl  (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [2:0] f_esize(input logic [2:0] s);
        if (s <= 3'd2) return 3'd3;
        if (s == 3'd7) return 3'd6;
        return s;
    endfunction

    function automatic int f_beats(input logic [2:0] s);
        return 1 << (int'(f_esize(s)) - 3);
    endfunction

    function automatic logic [63:0] f_merge(input logic [63:0] old, input logic [63:0] d,
                                            input logic [7:0] m);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Response driver: always ready, or the 1,0,0,1 pattern under back-pressure.
    initial begin
        int pidx;
        pidx = 0;
        bp_pat = 4'b1001;
        u_if.kl_resp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            u_if.kl_resp_ready = bp_mode ? bp_pat[pidx] : 1'b1;
            pidx = (pidx + 1) % 4;
        end
    end

    // Response monitor / scoreboard consumer.
    initial begin
        logic        stalled;
        logic [63:0] sv_rdata;
        logic        sv_ren;
        logic [2:0]  sv_size;
        logic [4:0]  sv_dstid;
        exp_t        e;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    chk("hold_valid", 64'(u_if.kl_resp_valid), 64'd1);
                    chk("hold_rdata", u_if.kl_resp_rdata, sv_rdata);
                    chk("hold_ren",   64'(u_if.kl_resp_ren), 64'(sv_ren));
                    chk("hold_size",  64'(u_if.kl_resp_size), 64'(sv_size));
                    chk("hold_dstid", 64'(u_if.kl_resp_dstid), 64'(sv_dstid));
                end
                stalled = 1'b0;
                if (u_if.kl_resp_valid) begin
                    chk("no_overlap", 64'(u_if.kl_req_ready), 64'd0);
                    if (!u_if.kl_resp_ready) begin
                        stalled  = 1'b1;
                        sv_rdata = u_if.kl_resp_rdata;
                        sv_ren   = u_if.kl_resp_ren;
                        sv_size  = u_if.kl_resp_size;
                        sv_dstid = u_if.kl_resp_dstid;
                    end else if (q.size() == 0) begin
                        chk("unexpected_resp", 64'd1, 64'd0);
                    end else begin
                        e = q.pop_front();
                        chk("resp_rdata", u_if.kl_resp_rdata, e.rdata);
                        chk("resp_ren",   64'(u_if.kl_resp_ren), 64'(e.ren));
                        chk("resp_size",  64'(u_if.kl_resp_size), 64'(e.size));
                        chk("resp_dstid", 64'(u_if.kl_resp_dstid), 64'(e.dstid));
                        if (e.ecyc >= 0) chk("resp_cycle", 64'(cyc), 64'(e.ecyc));
                        last_hs = cyc;
                    end
                end
            end
        end
    end

    task automatic drive_beat(input logic [31:0] a, input logic wen, input logic [63:0] d,
                              input logic [7:0] m, input logic [2:0] s, input logic [4:0] id,
                              output int acc);
        u_if.kl_req_addr  = a;
        u_if.kl_req_wen   = wen;
        u_if.kl_req_wdata = d;
        u_if.kl_req_wmask = m;
        u_if.kl_req_size  = s;
        u_if.kl_req_srcid = id;
        u_if.kl_req_valid = 1'b1;
        acc = -1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (u_if.kl_req_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) chk("req_accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        u_if.kl_req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (q.size() != 0 && n < 200);
        if (q.size() != 0) begin
            chk("drain_timeout", 64'(q.size()), 64'd0);
            q.delete();
        end
    endtask

    // Later beats carry a different size/srcid to confirm only wdata/wmask matter.
    task automatic do_write(input logic [31:0] a, input logic [2:0] s, input logic [4:0] id,
                            input logic [7:0] m, input logic [63:0] base, input int stop_at);
        int   nb, idx, acc;
        exp_t e;
        nb  = f_beats(s);
        idx = int'(a[c_DL+2:3]);
        for (int i = 0; i < nb; i++) begin
            if (stop_at >= 0 && i == stop_at) break;
            drive_beat(a, 1'b1, base + 64'(i), m, (i == 0) ? s : 3'd0,
                       (i == 0) ? id : ~id, acc);
            m_mem[(idx + i) % c_WORDS] = f_merge(m_mem[(idx + i) % c_WORDS], base + 64'(i), m);
            if (i == nb - 1) begin
                e.rdata = 64'd0; e.ren = 1'b0; e.size = f_esize(s); e.dstid = id; e.ecyc = acc + 1;
                q.push_back(e);
            end
        end
        if (stop_at < 0) wait_drain();
    endtask

    task automatic do_read(input logic [31:0] a, input logic [2:0] s, input logic [4:0] id,
                           input logic tight);
        int   nb, idx, acc;
        exp_t e;
        nb  = f_beats(s);
        idx = int'(a[c_DL+2:3]);
        drive_beat(a, 1'b0, {$urandom, $urandom}, 8'($urandom), s, id, acc);
        for (int k = 0; k < nb; k++) begin
            e.rdata = m_mem[(idx + k) % c_WORDS];
            e.ren   = 1'b1;
            e.size  = f_esize(s);
            e.dstid = id;
            e.ecyc  = tight ? (acc + 1 + k) : -1;
            q.push_back(e);
        end
        wait_drain();
        if (tight) begin
            @(negedge clk);
            chk("rd_ready_next", 64'(u_if.kl_req_ready), 64'd1);
            chk("rd_ready_cycle", 64'(cyc), 64'(last_hs + 1));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        last_hs  = 0;
        bp_mode  = 1'b0;
        for (int i = 0; i < c_WORDS; i++) m_mem[i] = 64'd0;
        rst               = 1'b1;
        u_if.kl_req_addr  = 32'h0;
        u_if.kl_req_wen   = 1'b1;
        u_if.kl_req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        u_if.kl_req_wmask = 8'hFF;
        u_if.kl_req_size  = 3'd3;
        u_if.kl_req_srcid = 5'd1;
        u_if.kl_req_valid = 1'b1;

        // Reset held three cycles with a pending request.
        repeat (3) begin
            @(negedge clk);
            chk("rst_req_ready",  64'(u_if.kl_req_ready), 64'd0);
            chk("rst_resp_valid", 64'(u_if.kl_resp_valid), 64'd0);
            chk("rst_resp_ren",   64'(u_if.kl_resp_ren), 64'd0);
            chk("rst_resp_rdata", u_if.kl_resp_rdata, 64'd0);
            chk("rst_resp_size",  64'(u_if.kl_resp_size), 64'd0);
            chk("rst_resp_dstid", 64'(u_if.kl_resp_dstid), 64'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        u_if.kl_req_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'(u_if.kl_req_ready), 64'd1);
        @(posedge clk);
        #1;

        // Masked write over a zeroed word, then read back with size 2.
        do_write(32'h10, 3'd3, 5'd1, 8'hFF, 64'd0, -1);
        do_write(32'h10, 3'd3, 5'd5, 8'h0F, 64'h1122334455667788, -1);
        do_read(32'h10, 3'd2, 5'd9, 1'b1);

        // Four-beat write burst, tight read back.
        do_write(32'h40, 3'd5, 5'd3, 8'hFF, 64'd1, -1);
        do_read(32'h40, 3'd5, 5'd4, 1'b1);

        // Eight-beat write, then read under back-pressure.
        do_write(32'h00, 3'd6, 5'd6, 8'hFF, 64'hA5A5_0000_0000_0000, -1);
        bp_mode = 1'b1;
        do_read(32'h00, 3'd6, 5'd10, 1'b0);
        bp_mode = 1'b0;
        @(posedge clk);
        #1;

        // Index wrap at the top of the array, address aliasing, size 7 as 6.
        do_write(32'h70, 3'd5, 5'd2, 8'hFF, 64'hC0DE_0000_0000_0000, -1);
        do_read(32'h70, 3'd3, 5'd11, 1'b1);
        do_read(32'h78, 3'd3, 5'd12, 1'b1);
        do_read(32'h00, 3'd3, 5'd13, 1'b1);
        do_read(32'h08, 3'd3, 5'd14, 1'b1);
        do_read(32'h90, 3'd0, 5'd15, 1'b1);
        do_read(32'h70, 3'd7, 5'd16, 1'b1);
        do_write(32'h18, 3'd4, 5'd17, 8'hA5, 64'h0123_4567_89AB_CDEF, -1);
        do_read(32'h18, 3'd4, 5'd18, 1'b1);

        // Reset after two beats of a four-beat write.
        do_write(32'h20, 3'd5, 5'd7, 8'hFF, 64'hDEAD_BEEF_0000_0000, 2);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("midrst_ready", 64'(u_if.kl_req_ready), 64'd0);
            chk("midrst_valid", 64'(u_if.kl_resp_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_ack", 64'(u_if.kl_resp_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        do_read(32'h20, 3'd5, 5'd19, 1'b1);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
